// File: rtl/hr_nic_pkg.sv
// Shared flit layout and widths for the hierarchical-ring network interface.
// Flit: [15] valid, [14:11] destination node, [10:0] payload.
package hr_nic_pkg;
  localparam int CONTROL_W     = 16;
  localparam int VALID_F       = 15;
  localparam int DEST_HI       = 14;
  localparam int DEST_LO       = 11;
  localparam int DEST_W        = DEST_HI - DEST_LO + 1;
  localparam int HR_DROP_CNT_W = 8;
endpackage

// File: rtl/hr_fifo.sv
// Single-push/single-pop FIFO with registered count; head is the oldest entry.
module hr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s, do_pop_s;

  assign full      = (count_r == CAP);
  assign empty     = (count_r == CW'(0));
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Storage array (contents are don't-care while empty)
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end
endmodule

// File: rtl/hr_nic.sv
// Local-side NIC for one hierarchical-ring node: per-ring injection FIFOs held until
// the node acks, and a shared dual-write ejection FIFO with drop/misroute reporting.
module hr_nic
  import hr_nic_pkg::*;
#(
  parameter logic [DEST_W-1:0] addr = 4'b0010,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CONTROL_W-1:0]     inj_flit_i,
  input  logic                     inj_valid_i,
  input  logic                     inj_ring_i,
  output logic                     inj_ready_o,
  output logic [CONTROL_W-1:0]     ring0_inj_o,
  output logic [CONTROL_W-1:0]     ring1_inj_o,
  input  logic                     ring0_ack_i,
  input  logic                     ring1_ack_i,
  input  logic [CONTROL_W-1:0]     ring0_ej_i,
  input  logic [CONTROL_W-1:0]     ring1_ej_i,
  output logic [CONTROL_W-1:0]     ej_flit_o,
  output logic                     ej_valid_o,
  input  logic                     ej_ready_i,
  output logic                     ej_drop_o,
  output logic                     ej_misroute_o,
  output logic [HR_DROP_CNT_W-1:0] ej_drop_cnt_o
);
  localparam int EJ_PW = $clog2(EJ_DEPTH);
  localparam int EJ_CW = EJ_PW + 1;
  localparam logic [EJ_CW-1:0] EJ_CAP = EJ_CW'(EJ_DEPTH);

  logic                 full0_s, full1_s, empty0_s, empty1_s;
  logic [CONTROL_W-1:0] head0_s, head1_s, inj_data_s;

  assign inj_data_s  = inj_flit_i | (CONTROL_W'(1) << VALID_F);
  assign inj_ready_o = inj_ring_i ? ~full1_s : ~full0_s;
  // Outputs depend only on FIFO state: the node's ack is combinational on them.
  assign ring0_inj_o = empty0_s ? CONTROL_W'(0) : head0_s;
  assign ring1_inj_o = empty1_s ? CONTROL_W'(0) : head1_s;

  hr_fifo #(.WIDTH(CONTROL_W), .DEPTH(INJ_DEPTH)) u_inj0 (
    .clk(clk), .rst(rst),
    .push(inj_valid_i & ~inj_ring_i), .push_data(inj_data_s), .pop(ring0_ack_i),
    .full(full0_s), .empty(empty0_s), .head(head0_s)
  );

  hr_fifo #(.WIDTH(CONTROL_W), .DEPTH(INJ_DEPTH)) u_inj1 (
    .clk(clk), .rst(rst),
    .push(inj_valid_i & inj_ring_i), .push_data(inj_data_s), .pop(ring1_ack_i),
    .full(full1_s), .empty(empty1_s), .head(head1_s)
  );

  logic [CONTROL_W-1:0]     ej_mem_r [EJ_DEPTH];
  logic [EJ_PW-1:0]         ej_wr_r, ej_rd_r, ej_wr1_s;
  logic [EJ_CW-1:0]         ej_cnt_r, ej_free_s;
  logic                     v0_s, v1_s, st0_s, st1_s, drop0_s, drop1_s, pop_s, mis_s;
  logic [HR_DROP_CNT_W:0]   drop_sum_s;
  logic                     drop_r, mis_r;
  logic [HR_DROP_CNT_W-1:0] drop_cnt_r;

  // Ejection admission: ring0 has priority on the last free slot
  always_comb begin
    v0_s      = ring0_ej_i[VALID_F];
    v1_s      = ring1_ej_i[VALID_F];
    ej_free_s = EJ_CAP - ej_cnt_r;
    st0_s     = v0_s && (ej_free_s != EJ_CW'(0));
    if (v0_s) begin
      st1_s = v1_s && (ej_free_s >= EJ_CW'(2));
    end else begin
      st1_s = v1_s && (ej_free_s != EJ_CW'(0));
    end
    drop0_s    = v0_s & ~st0_s;
    drop1_s    = v1_s & ~st1_s;
    ej_wr1_s   = st0_s ? ej_wr_r + EJ_PW'(1) : ej_wr_r;
    pop_s      = ej_ready_i && (ej_cnt_r != EJ_CW'(0));
    drop_sum_s = {1'b0, drop_cnt_r} + (HR_DROP_CNT_W+1)'(drop0_s) + (HR_DROP_CNT_W+1)'(drop1_s);
    mis_s      = (v0_s && (ring0_ej_i[DEST_HI:DEST_LO] != addr)) ||
                 (v1_s && (ring1_ej_i[DEST_HI:DEST_LO] != addr));
  end

  // Ejection pointers, occupancy and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      ej_wr_r    <= EJ_PW'(0);
      ej_rd_r    <= EJ_PW'(0);
      ej_cnt_r   <= EJ_CW'(0);
      drop_r     <= 1'b0;
      mis_r      <= 1'b0;
      drop_cnt_r <= HR_DROP_CNT_W'(0);
    end else begin
      ej_wr_r  <= ej_wr_r + EJ_PW'(st0_s) + EJ_PW'(st1_s);
      if (pop_s) ej_rd_r <= ej_rd_r + EJ_PW'(1);
      ej_cnt_r <= ej_cnt_r + EJ_CW'(st0_s) + EJ_CW'(st1_s) - EJ_CW'(pop_s);
      if (drop0_s | drop1_s) drop_r <= 1'b1;
      if (mis_s) mis_r <= 1'b1;
      drop_cnt_r <= drop_sum_s[HR_DROP_CNT_W] ? {HR_DROP_CNT_W{1'b1}}
                                              : drop_sum_s[HR_DROP_CNT_W-1:0];
    end
  end

  // Ejection storage
  always_ff @(posedge clk) begin
    if (st0_s) ej_mem_r[ej_wr_r]  <= ring0_ej_i;
    if (st1_s) ej_mem_r[ej_wr1_s] <= ring1_ej_i;
  end

  assign ej_valid_o    = (ej_cnt_r != EJ_CW'(0));
  assign ej_flit_o     = ej_valid_o ? ej_mem_r[ej_rd_r] : CONTROL_W'(0);
  assign ej_drop_o     = drop_r;
  assign ej_misroute_o = mis_r;
  assign ej_drop_cnt_o = drop_cnt_r;
endmodule
